// File: rtl/lzc_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : lzc_norm_pipe
//  Description : Two-stage pipelined leading-zero counter and left normaliser
//                for FP mantissas. Stage 1 counts leading zeros with a
//                balanced binary tree; stage 2 applies the shift, capped by a
//                per-transaction maximum. Valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module lzc_norm_pipe #(
  parameter int WIDTH = 48,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_max_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_lz,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_zero
);

  // Tree depth and the power-of-two width it operates on
  localparam int L = $clog2(WIDTH);
  localparam int P = 1 << L;

  // --------------------------------------------------------------------------
  // Leading-zero tree. Padding with ones below the LSB means an all-zero input
  // naturally counts to WIDTH when WIDTH is not a power of two.
  // --------------------------------------------------------------------------
  logic [P-1:0] w_pad;

  if (P > WIDTH) begin : g_pad
    assign w_pad = {in_data, {(P - WIDTH){1'b1}}};
  end else begin : g_nopad
    assign w_pad = in_data;
  end

  // Level h holds P>>h nodes; node j covers pad bits [(j+1)*2^h-1 : j*2^h].
  // w_v = "a one exists in this span", w_c = zeros above that first one.
  for (genvar h = 1; h <= L; h++) begin : g_lvl
    localparam int N = P >> h;
    logic [N-1:0]        w_v;
    logic [N-1:0][h-1:0] w_c;
    if (h == 1) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_node
        assign w_v[j] = w_pad[2*j+1] | w_pad[2*j];
        assign w_c[j] = ~w_pad[2*j+1];
      end
    end else begin : g_merge
      for (genvar j = 0; j < N; j++) begin : g_node
        assign w_v[j] = g_lvl[h-1].w_v[2*j+1] | g_lvl[h-1].w_v[2*j];
        assign w_c[j] = g_lvl[h-1].w_v[2*j+1] ? {1'b0, g_lvl[h-1].w_c[2*j+1]}
                                              : {1'b1, g_lvl[h-1].w_c[2*j]};
      end
    end
  end

  // Root never reports "no one" unless WIDTH is an exact power of two
  logic [CNT_W-1:0] w_lz;
  logic             w_zero;
  assign w_lz   = g_lvl[L].w_v[0] ? CNT_W'(g_lvl[L].w_c[0]) : CNT_W'(WIDTH);
  assign w_zero = (in_data == '0);

  // --------------------------------------------------------------------------
  // Flow control: a stage is free if empty or if its contents leave this cycle
  // --------------------------------------------------------------------------
  logic r_s1_valid, r_s2_valid;
  logic w_s1_free, w_s2_free, w_load1, w_load2;

  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_free = !r_s1_valid || w_s2_free;
  assign w_load1   = in_valid && w_s1_free;
  assign w_load2   = r_s1_valid && w_s2_free;
  assign in_ready  = w_s1_free;

  // Stage valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_free) r_s1_valid <= in_valid;
      if (w_s2_free) r_s2_valid <= r_s1_valid;
    end
  end

  // Stage 1 data: capture operand, cap and count
  logic [WIDTH-1:0] r_s1_data;
  logic [CNT_W-1:0] r_s1_max, r_s1_lz;
  logic             r_s1_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data <= '0;
      r_s1_max  <= '0;
      r_s1_lz   <= '0;
      r_s1_zero <= 1'b0;
    end else if (w_load1) begin
      r_s1_data <= in_data;
      r_s1_max  <= in_max_shift;
      r_s1_lz   <= w_lz;
      r_s1_zero <= w_zero;
    end
  end

  // Applied shift is the count clamped to the caller's limit
  logic [CNT_W-1:0] w_shift;
  assign w_shift = (r_s1_lz < r_s1_max) ? r_s1_lz : r_s1_max;

  // Stage 2 data: normalised mantissa plus pass-through status
  logic [WIDTH-1:0] r_s2_data;
  logic [CNT_W-1:0] r_s2_lz, r_s2_shift;
  logic             r_s2_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_data  <= '0;
      r_s2_lz    <= '0;
      r_s2_shift <= '0;
      r_s2_zero  <= 1'b0;
    end else if (w_load2) begin
      r_s2_data  <= r_s1_data << w_shift;
      r_s2_lz    <= r_s1_lz;
      r_s2_shift <= w_shift;
      r_s2_zero  <= r_s1_zero;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_lz    = r_s2_lz;
  assign out_shift = r_s2_shift;
  assign out_zero  = r_s2_zero;

endmodule
`default_nettype wire

// File: tb/tb_lzc_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lzc_norm_pipe
//  Description : Directed and scoreboarded bench for lzc_norm_pipe (WIDTH=48)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lzc_norm_pipe;

  localparam int W  = 48;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [CW-1:0] in_max_shift = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_lz;
  logic [CW-1:0] out_shift;
  logic          out_zero;

  int checks = 0;
  int errors = 0;

  lzc_norm_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_max_shift(in_max_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lz(out_lz), .out_shift(out_shift), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // Reference leading-zero count
  function automatic int lz_ref(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return W - 1 - i;
    end
    return W;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_lz, out_shift, out_zero} !== {1'b1, 1'b0, 48'h0, 6'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b d=%h lz=%0d sh=%0d z=%b, want rdy=1 v=0 d=0 lz=0 sh=0 z=0",
               in_ready, out_valid, out_data, out_lz, out_shift, out_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0]  td [8];
    logic [CW-1:0] tm [8];
    logic [W-1:0]  ed [8];
    logic [CW-1:0] el [8];
    logic [CW-1:0] es [8];
    logic          ez [8];
    td[0] = 48'h0000_0001_0000; tm[0] = 63; ed[0] = 48'h8000_0000_0000; el[0] = 31; es[0] = 31; ez[0] = 0;
    td[1] = 48'h0000_0000_0000; tm[1] = 63; ed[1] = 48'h0000_0000_0000; el[1] = 48; es[1] = 48; ez[1] = 1;
    td[2] = 48'h8000_0000_0001; tm[2] = 63; ed[2] = 48'h8000_0000_0001; el[2] = 0;  es[2] = 0;  ez[2] = 0;
    td[3] = 48'h0000_0000_00FF; tm[3] = 10; ed[3] = 48'h0000_0003_FC00; el[3] = 40; es[3] = 10; ez[3] = 0;
    td[4] = 48'h0000_0000_00FF; tm[4] = 0;  ed[4] = 48'h0000_0000_00FF; el[4] = 40; es[4] = 0;  ez[4] = 0;
    td[5] = 48'h0000_0000_0001; tm[5] = 50; ed[5] = 48'h8000_0000_0000; el[5] = 47; es[5] = 47; ez[5] = 0;
    td[6] = 48'h0000_0000_0000; tm[6] = 5;  ed[6] = 48'h0000_0000_0000; el[6] = 48; es[6] = 5;  ez[6] = 1;
    td[7] = 48'h0123_4567_89AB; tm[7] = 63; ed[7] = 48'h91A2_B3C4_D580; el[7] = 7;  es[7] = 7;  ez[7] = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_data = td[i]; in_max_shift = tm[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_latency[%0d]: out_valid=%b after 1 cycle, want 0", i, out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({out_valid, out_lz, out_shift, out_zero, out_data} !== {1'b1, el[i], es[i], ez[i], ed[i]}) begin
        errors++;
        $display("FAIL basic_result[%0d]: got v=%b lz=%0d sh=%0d z=%b d=%h, want v=1 lz=%0d sh=%0d z=%b d=%h",
                 i, out_valid, out_lz, out_shift, out_zero, out_data, el[i], es[i], ez[i], ed[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int sent = 0;
    logic          exp_rdy, exp_v;
    logic [CW-1:0] exp_lz;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      out_ready    = (c >= 6);
      in_valid     = (sent < 4);
      in_data      = 48'h1 << sent;
      in_max_shift = 63;
      #1;
      exp_rdy = (c < 2) || (c >= 6);
      exp_v   = (c >= 2) && (c <= 9);
      exp_lz  = (c <= 6) ? 6'd47 : 6'(47 - (c - 6));
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_in_ready[c=%0d]: got %b want %b", c, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL bp_out_valid[c=%0d]: got %b want %b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if ({out_lz, out_shift, out_data} !== {exp_lz, exp_lz, 48'h8000_0000_0000}) begin
          errors++;
          $display("FAIL bp_data[c=%0d]: got lz=%0d sh=%0d d=%h want lz=%0d sh=%0d d=800000000000",
                   c, out_lz, out_shift, out_data, exp_lz, exp_lz);
        end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != 4) begin
      errors++;
      $display("FAIL bp_accepted: got %0d want 4", sent);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0]  q_d [$];
    logic [CW-1:0] q_m [$];
    logic [63:0]   rnd;
    logic [W-1:0]  d;
    logic [CW-1:0] m, exp_lz, exp_sh;
    int sent = 0, rcvd = 0, cyc = 0, occ;
    logic pending = 1'b0;
    while ((rcvd < 100) && (cyc < 2000)) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 1) == 1);
      if (!pending) begin
        if ((sent < 100) && ($urandom_range(0, 3) != 0)) begin
          rnd = {$urandom(), $urandom()};
          in_data      = rnd[W-1:0] >> $urandom_range(0, W);
          in_max_shift = 6'($urandom_range(0, 63));
          in_valid     = 1'b1;
          pending      = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      occ = q_d.size();
      if (out_ready) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_throughput[cyc=%0d]: in_ready=%b with out_ready=1", cyc, in_ready);
        end
      end
      if (occ == 2) begin
        checks++;
        if ({out_valid, in_ready} !== {1'b1, out_ready}) begin
          errors++;
          $display("FAIL stream_full[cyc=%0d]: got v=%b rdy=%b want v=1 rdy=%b", cyc, out_valid, in_ready, out_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (occ == 0) begin
          errors++;
          $display("FAIL stream_spurious[cyc=%0d]: output with empty scoreboard", cyc);
        end else begin
          d = q_d.pop_front();
          m = q_m.pop_front();
          exp_lz = 6'(lz_ref(d));
          exp_sh = (exp_lz < m) ? exp_lz : m;
          if ({out_lz, out_shift, out_zero, out_data} !== {exp_lz, exp_sh, (d == '0), d << exp_sh}) begin
            errors++;
            $display("FAIL stream_data[%0d]: got lz=%0d sh=%0d z=%b d=%h want lz=%0d sh=%0d z=%b d=%h",
                     rcvd, out_lz, out_shift, out_zero, out_data, exp_lz, exp_sh, (d == '0), d << exp_sh);
          end
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q_d.push_back(in_data);
        q_m.push_back(in_max_shift);
        sent++;
        pending = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ((rcvd != 100) || (sent != 100)) begin
      errors++;
      $display("FAIL stream_count: sent=%0d rcvd=%0d want 100/100 (cycles=%0d)", sent, rcvd, cyc);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 48'h0000_0000_0003; in_max_shift = 63;
    @(negedge clk);
    in_data = 48'h0000_0000_0007;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_full: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_lz, out_shift, out_zero} !== {1'b0, 48'h0, 6'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_async: got v=%b d=%h lz=%0d sh=%0d z=%b want all zero",
               out_valid, out_data, out_lz, out_shift, out_zero);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 48'h0000_00F0_0000; in_max_shift = 63;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_replay: out_valid=%b one cycle after release, want 0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_lz, out_shift, out_zero, out_data} !== {1'b1, 6'd24, 6'd24, 1'b0, 48'hF000_0000_0000}) begin
      errors++;
      $display("FAIL midrst_first: got v=%b lz=%0d sh=%0d z=%b d=%h want v=1 lz=24 sh=24 z=0 d=f00000000000",
               out_valid, out_lz, out_shift, out_zero, out_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
